// File: rtl/mycpu_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with sign handling around an unsigned magnitude core.
module mycpu_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int SIGNED_EN  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = ($clog2(W) + 1 < 5) ? 5 : $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic            dz_q, dz_d, dbz_q, dbz_d;

  logic            accept, req_div, req_signed, a_neg, b_neg, b_zero;
  logic [W-1:0]    abs_a, abs_b;

  assign accept     = (state_q == S_IDLE) && req_valid && !flush;
  assign req_div    = op[1];
  assign req_signed = (SIGNED_EN != 0) && !op[0];
  assign a_neg      = req_signed && src_a[W-1];
  assign b_neg      = req_signed && src_b[W-1];
  assign abs_a      = a_neg ? -src_a : src_a;
  assign abs_b      = b_neg ? -src_b : src_b;
  assign b_zero     = (src_b == '0);

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}.
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix, rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod_fix  = neg_lo_q ? -acc_q : acc_q;
    quot_fix  = neg_lo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix   = neg_hi_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = (req_div && b_zero) ? S_FIX : S_CALC;
      S_CALC: if (flush) state_d = S_IDLE;
              else if (cnt_q == CW'(W)) state_d = S_FIX;
      S_FIX:  state_d = flush ? S_IDLE : S_DONE;
      S_DONE: if (flush || resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        is_div_d = req_div;
        cnt_d    = '0;
        dz_d     = req_div && b_zero;
        if (req_div && b_zero) begin
          acc_d    = {src_a, {W{1'b1}}};
          neg_lo_d = 1'b0;
          neg_hi_d = 1'b0;
        end else begin
          opnd_d   = req_div ? abs_b : abs_a;
          acc_d    = {{W{1'b0}}, (req_div ? abs_a : abs_b)};
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = req_div && a_neg;
        end
      end
      S_CALC: if (cnt_q != CW'(W)) begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q)
          acc_d = {(div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0]),
                   acc_q[W-2:0], !div_diff[W]};
        else
          acc_d = {mul_sum, acc_q[W-1:1]};
      end
      S_FIX: if (!flush) begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        dbz_d = dz_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mycpu_muldiv.sv
// Self-checking bench for mycpu_muldiv: directed corner cases, randomized ops
// against an arithmetic reference, stall/back-to-back, flush and reset abort.
module tb_mycpu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn, req_valid, flush, resp_ready;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         req_ready, resp_valid, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mycpu_muldiv #(.DATA_WIDTH(W), .SIGNED_EN(1)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  // Reference computed with 64-bit integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, b,
                                output logic [W-1:0] eh, el, output logic ed);
    longint      p, sa, sb, q, r;
    logic [63:0] up;
    ed = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {eh, el} = p;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        {eh, el} = up;
      end
      default: begin
        if (b == 0) begin
          el = '1; eh = a; ed = 1'b1;
        end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000; eh = '0;
        end else if (o == 2'b10) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          el = q[31:0];
          eh = r[31:0];
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, b);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready got=%b exp=1", req_ready);
    end
    req_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_resp(input string name, input int exp_lat);
    int lat = 0;
    while (resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
    end
  endtask

  task automatic check_result(input string name, input logic [1:0] o, input logic [W-1:0] a, b);
    logic [W-1:0] eh, el;
    logic         ed;
    model(o, a, b, eh, el, ed);
    checks++;
    if (hi !== eh || lo !== el || div_by_zero !== ed) begin
      failures++;
      $display("FAIL %s op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b exp hi=%h lo=%h dbz=%b",
               name, o, a, b, hi, lo, div_by_zero, eh, el, ed);
    end
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s consume got valid=%b ready=%b exp valid=0 ready=1", name, resp_valid, req_ready);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a, b);
    issue(o, a, b);
    wait_resp(name, (o[1] && b == 0) ? 1 : W + 2);
    check_result(name, o, a, b);
    consume(name);
  endtask

  task automatic expect_silence(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL %s resp_valid_cycles got=%0d exp=0", name, seen);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || hi !== '0 || lo !== '0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset got ready=%b valid=%b hi=%h lo=%h dbz=%b exp 1 0 0 0 0",
               req_ready, resp_valid, hi, lo, div_by_zero);
    end
  endtask

  task automatic test_directed();
    run_op("mult_m1_x2",  2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("divu_by0",    2'b11, 32'h0000_0007, 32'h0000_0000);
    run_op("div_by0",     2'b10, 32'h8000_0001, 32'h0000_0000);
    run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_7_m2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE);
    run_op("mult_minneg", 2'b00, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_random();
    logic [1:0]   o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = W'($urandom_range(1, 15));
        3: a = W'($urandom_range(0, 15));
        default: ;
      endcase
      run_op("random", o, a, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eh, el, a1, b1, a2, b2;
    logic         ed;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = W'($urandom_range(1, 1000));
    model(2'b00, a1, b1, eh, el, ed);
    issue(2'b00, a1, b1);
    wait_resp("stall", W + 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; op = 2'b11; src_a = a2; src_b = b2;
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || hi !== eh || lo !== el || div_by_zero !== ed) begin
        failures++;
        $display("FAIL stall cyc=%0d got valid=%b ready=%b hi=%h lo=%h exp valid=1 ready=0 hi=%h lo=%h",
                 i, resp_valid, req_ready, hi, lo, eh, el);
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL handshake_no_accept got valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept got ready=%b exp=0", req_ready);
    end
    wait_resp("b2b", W + 2);
    check_result("b2b", 2'b11, a2, b2);
    consume("b2b");
  endtask

  task automatic test_flush();
    issue(2'b11, $urandom, W'($urandom_range(1, 255)));
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_calc got valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready);
    end
    expect_silence("flush_calc", 40);

    issue(2'b10, $urandom, '0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_fix got valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready);
    end
    expect_silence("flush_fix", 5);

    issue(2'b01, $urandom, $urandom);
    wait_resp("flush_done", W + 2);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_done got valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready);
    end

    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle got ready=%b exp=1", req_ready);
    end
    expect_silence("flush_idle", 40);
    run_op("divu_after_flush", 2'b11, 32'd100, 32'd7);
  endtask

  task automatic test_reset_mid();
    issue(2'b00, $urandom, $urandom);
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_mid got valid=%b ready=%b hi=%h lo=%h exp 0 1 0 0", resp_valid, req_ready, hi, lo);
    end
    @(negedge clk);
    resetn = 1'b1;
    expect_silence("reset_mid", 40);
    issue(2'b11, 32'd100, 32'd7);
    wait_resp("divu_after_reset", W + 2);
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL divu_after_reset got lo=%0d hi=%0d dbz=%b exp lo=14 hi=2 dbz=0", lo, hi, div_by_zero);
    end
    consume("divu_after_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mycpu_muldiv.md
MYCPU_MULDIV -- requirements
Module: mycpu_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width W (even, >=8).
REQ-002 SHALL have parameter SIGNED_EN, default 1; 0 treats signed ops as unsigned.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept request.
REQ-007 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-008 SHALL have port src_a  input  W  multiplicand/dividend.
REQ-009 SHALL have port src_b  input  W  multiplier/divisor.
REQ-010 SHALL have port flush  input  1  cancel in-flight operation.
REQ-011 SHALL have port resp_valid  output  1  result present.
REQ-012 SHALL have port resp_ready  input  1  consumer takes result.
REQ-013 SHALL have port hi  output  W  product high half / remainder.
REQ-014 SHALL have port lo  output  W  product low half / quotient.
REQ-015 SHALL have port div_by_zero  output  1  flag, valid with resp_valid.

Function
REQ-016 SHALL implement FSM IDLE, CALC, FIX, DONE; req_ready=1 only in IDLE.
REQ-017 SHALL accept a request on an edge where req_valid & req_ready, latch op/operands, go IDLE->CALC.
REQ-018 SHALL, for signed ops, latch absolute values of operands and record result signs (product sign a^b, quotient a^b, remainder sign of a).
REQ-019 SHALL perform exactly W iterations in CALC: radix-2 shift-add multiply, restoring divide one quotient bit per cycle, 5+ bit iteration counter.
REQ-020 SHALL go CALC->FIX after iteration W, apply two's-complement sign correction in FIX (2W-bit for product), then FIX->DONE.
REQ-021 SHALL assert resp_valid in DONE only; first cycle resp_valid is high is W+2 edges after the accepting edge.
REQ-022 SHALL hold hi/lo/div_by_zero stable while resp_valid & !resp_ready.
REQ-023 SHALL go DONE->IDLE on edge with resp_valid & resp_ready; no new request accepted that same edge.
REQ-024 SHALL, on divide by zero, skip CALC (IDLE->FIX), return lo=all ones, hi=src_a, div_by_zero=1.
REQ-025 SHALL, on signed DIV of most-negative by -1, return lo=most-negative, hi=0, div_by_zero=0.
REQ-026 SHALL, for MULT/MULTU, produce exact 2W-bit product {hi,lo}; MULT with SIGNED_EN=0 behaves as MULTU.
REQ-027 SHALL ensure DIV satisfies a = q*b + r, |r|<|b|, remainder sign equal to dividend sign.
REQ-028 SHALL, on flush high in CALC or FIX, return to IDLE next edge with no resp_valid; flush in DONE discards result; flush in IDLE ignored and overrides simultaneous req_valid.
REQ-029 SHALL keep hi/lo unchanged outside DONE except updating internal accumulators; outputs register-driven.

Reset
REQ-030 SHALL, on resetn low, immediately enter IDLE, clear counter, drive resp_valid=0, req_ready=1 after release, hi=0, lo=0, div_by_zero=0.
REQ-031 SHALL abandon any in-flight operation on reset without producing a response.

Verification
REQ-032 SHALL test MULT a=0xFFFFFFFF(-1), b=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, resp_valid 34 edges after accept.
REQ-033 SHALL test MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 SHALL test DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7,b=0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1.
REQ-035 SHALL test DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 SHALL test resp_ready held low 5 cycles -> outputs stable, req_ready=0; then back-to-back request accepted the cycle after handshake.
REQ-037 SHALL test flush at iteration 10 and resetn low mid-CALC -> no resp_valid, req_ready=1 next cycle, subsequent DIVU 100/7 -> lo=14, hi=2.
